// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encoding and defaults for the input debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Bit 1 of every state code is the committed debounced level.
  localparam logic [1:0] ST_STABLE_LO = 2'b00;
  localparam logic [1:0] ST_WAIT_HI   = 2'b01;
  localparam logic [1:0] ST_STABLE_HI = 2'b11;
  localparam logic [1:0] ST_WAIT_LO   = 2'b10;

  localparam int DEFAULT_STABLE_CYCLES = 500000;

  typedef enum logic [1:0] {
    S_STABLE_LO = ST_STABLE_LO,
    S_WAIT_HI   = ST_WAIT_HI,
    S_STABLE_HI = ST_STABLE_HI,
    S_WAIT_LO   = ST_WAIT_LO
  } state_t;

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : debounce_ch
// Description : Single-channel synchronizer, qualification FSM and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_rise;
  logic             r_fall;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_sync1 <= 1'b0;
      r_sync  <= 1'b0;
      r_state <= S_STABLE_LO;
      r_count <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync  <= r_sync1;
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // The count saturates at c_cnt_last by committing, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      S_STABLE_LO: begin
        if (r_sync) begin
          w_state_nxt = S_WAIT_HI;
          w_count_nxt = c_cnt_one;
        end
      end
      S_WAIT_HI: begin
        if (!r_sync) begin
          w_state_nxt = S_STABLE_LO;
          w_count_nxt = '0;
        end else if (r_count == c_cnt_last) begin
          w_state_nxt = S_STABLE_HI;
          w_count_nxt = '0;
          w_rise_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + c_cnt_one;
        end
      end
      S_STABLE_HI: begin
        if (!r_sync) begin
          w_state_nxt = S_WAIT_LO;
          w_count_nxt = c_cnt_one;
        end
      end
      S_WAIT_LO: begin
        if (r_sync) begin
          w_state_nxt = S_STABLE_HI;
          w_count_nxt = '0;
        end else if (r_count == c_cnt_last) begin
          w_state_nxt = S_STABLE_LO;
          w_count_nxt = '0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = S_STABLE_LO;
        w_count_nxt = '0;
      end
    endcase
  end

  assign level = r_state[1];
  assign busy  = r_state[1] ^ r_state[0];
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : WIDTH independent debounce channels for raw board inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] busy
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .Clk   (Clk),
      .Resetn(Resetn),
      .raw   (raw_in[g]),
      .level (D[g]),
      .rise  (rise[g]),
      .fall  (fall[g]),
      .busy  (busy[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debounce
// Description : Directed self-checking bench for input_debounce (N=4, W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce;

  localparam int WIDTH         = 2;
  localparam int STABLE_CYCLES = 4;

  logic             Clk = 1'b0;
  logic             Resetn;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] busy;

  int n_checks = 0;
  int n_errors = 0;

  input_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .Clk   (Clk),
    .Resetn(Resetn),
    .raw_in(raw_in),
    .D     (D),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int e_d, input int e_r,
                           input int e_f, input int e_b);
    check({tag, ".D"},    32'(D),    e_d);
    check({tag, ".rise"}, 32'(rise), e_r);
    check({tag, ".fall"}, 32'(fall), e_f);
    check({tag, ".busy"}, 32'(busy), e_b);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  int pat [7] = '{1, 1, 0, 1, 1, 1, 1};

  initial begin
    Resetn = 1'b0;
    raw_in = 2'b11;

    // 1: reset with inputs high, then full qualification from scratch
    repeat (3) begin
      step();
      check_all("t1_rst", 0, 0, 0, 0);
    end
    Resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("t1_qual", (i == 5) ? 3 : 0, (i == 5) ? 3 : 0, 0,
                (i >= 2 && i <= 4) ? 3 : 0);
    end
    step();
    check_all("t1_hold", 3, 0, 0, 0);
    raw_in = 2'b00;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("t1_drop", (i == 5) ? 0 : 3, 0, (i == 5) ? 3 : 0,
                (i >= 2 && i <= 4) ? 3 : 0);
    end
    step();
    check_all("t1_idle", 0, 0, 0, 0);

    // 2: clean rise and fall on channel 0 only
    raw_in = 2'b01;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("t2_rise", (i == 5) ? 1 : 0, (i == 5) ? 1 : 0, 0,
                (i >= 2 && i <= 4) ? 1 : 0);
    end
    step();
    check_all("t2_rise_clr", 1, 0, 0, 0);
    raw_in = 2'b00;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("t2_fall", (i == 5) ? 0 : 1, 0, (i == 5) ? 1 : 0,
                (i >= 2 && i <= 4) ? 1 : 0);
    end
    step();
    check_all("t2_fall_clr", 0, 0, 0, 0);

    // 3: bounce 1,1,0,1,1,1,1 -- abort, then a single rise 5 edges after last 0->1
    for (int i = 0; i < 10; i++) begin
      raw_in = {1'b0, (i < 7) ? pat[i][0] : 1'b1};
      step();
      check_all("t3_bounce", (i >= 8) ? 1 : 0, (i == 8) ? 1 : 0, 0,
                (i == 2 || i == 3 || (i >= 5 && i <= 7)) ? 1 : 0);
    end
    raw_in = 2'b00;
    for (int i = 0; i < 7; i++) begin
      step();
      check_all("t3_drop", (i >= 5) ? 0 : 1, 0, (i == 5) ? 1 : 0,
                (i >= 2 && i <= 4) ? 1 : 0);
    end

    // 4: channel 1 glitch of 3 cycles never commits
    for (int i = 0; i < 8; i++) begin
      raw_in = (i < 3) ? 2'b10 : 2'b00;
      step();
      check_all("t4_glitch", 0, 0, 0, (i >= 2 && i <= 4) ? 2 : 0);
    end

    // 5: reset while channel 0 is in WAIT_HI with count=3
    raw_in = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("t5_pre", 0, 0, 0, (i >= 2) ? 1 : 0);
    end
    Resetn = 1'b0;
    step();
    check_all("t5_rst", 0, 0, 0, 0);
    Resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("t5_requal", (i == 5) ? 1 : 0, (i == 5) ? 1 : 0, 0,
                (i >= 2 && i <= 4) ? 1 : 0);
    end
    step();
    check_all("t5_hold", 1, 0, 0, 0);
    raw_in = 2'b00;
    repeat (7) step();
    check_all("t5_idle", 0, 0, 0, 0);

    // 6: both channels commit together
    raw_in = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("t6_both", (i == 5) ? 3 : 0, (i == 5) ? 3 : 0, 0,
                (i >= 2 && i <= 4) ? 3 : 0);
    end
    step();
    check_all("t6_hold", 3, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
